// File: rtl/argmax_fp_if.sv
// Handshake and data bundle between a matmul result producer and argmax_fp.
// The master drives start/in; the slave (argmax_fp) returns the classification result.
interface argmax_fp_if #(
    parameter int S  = 32,
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
);
    logic          start;
    logic [N*S-1:0] in;
    logic [IW-1:0] idx;
    logic [S-1:0]  max_val;
    logic          busy;
    logic          done;

    modport master (output start, output in, input idx, input max_val, input busy, input done);
    modport slave  (input start, input in, output idx, output max_val, output busy, output done);
endinterface

// File: rtl/argmax_fp.sv
// Serial argmax over a packed float32 vector: one compare per clock, reports index
// and raw bits of the largest element using a total order on the IEEE-754 bit pattern.
module argmax_fp #(
    parameter int S  = 32,
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic        clk,
    input  logic        rst_n,
    argmax_fp_if.slave  bus
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r;
    logic [N*S-1:0] vec_r;
    logic [CW-1:0]  cnt_r;
    logic [IW-1:0]  idx_r;
    logic [S-1:0]   max_r;
    logic           busy_r;
    logic           done_r;
    logic [S-1:0]   cur_s;

    // Map float bits to an unsigned key whose ordering matches numeric ordering
    // (negatives inverted, positives offset above them; -0 sorts just below +0).
    function automatic logic [S-1:0] fp_key(input logic [S-1:0] x);
        logic [S-1:0] k;
        if (x[S-1]) begin
            k = ~x;
        end else begin
            k = {1'b1, x[S-2:0]};
        end
        return k;
    endfunction

    // Element k sits in the k-th most-significant slice; out-of-range reads return zero.
    function automatic logic [S-1:0] elem_at(input logic [N*S-1:0] v, input logic [CW-1:0] k);
        logic [S-1:0] e;
        if (int'(k) < N) begin
            e = v[(N-1-int'(k))*S +: S];
        end else begin
            e = {S{1'b0}};
        end
        return e;
    endfunction

    assign cur_s = elem_at(vec_r, cnt_r);

    // Scan FSM with registered result, busy and done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            vec_r   <= {(N*S){1'b0}};
            cnt_r   <= {CW{1'b0}};
            idx_r   <= {IW{1'b0}};
            max_r   <= {S{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        vec_r <= bus.in;
                        max_r <= bus.in[N*S-1 -: S];
                        idx_r <= {IW{1'b0}};
                        cnt_r <= CW'(1);
                        if (N == 1) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= SCAN;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if (fp_key(cur_s) > fp_key(max_r)) begin
                        max_r <= cur_s;
                        idx_r <= cnt_r[IW-1:0];
                    end else begin
                        max_r <= max_r;
                        idx_r <= idx_r;
                    end
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CW'(N-1)) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= SCAN;
                        done_r  <= 1'b0;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.idx     = idx_r;
    assign bus.max_val = max_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
endmodule

// File: tb/tb_argmax_fp.sv
// Directed bench for argmax_fp (N=4, float32): timing, ordering, abort and back-to-back scans.
module tb_argmax_fp;
    localparam int S  = 32;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    argmax_fp_if #(.S(S), .N(N), .IW(IW)) bus ();

    argmax_fp #(.S(S), .N(N), .IW(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.in    = {32'h3f800000, 32'h40000000, 32'hbf800000, 32'h3f000000};
        repeat (3) @(negedge clk);
        n_assert++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: done=%b busy=%b required 0 0", bus.done, bus.busy);
        end
        n_assert++;
        if (bus.idx !== 2'd0 || bus.max_val !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_result: idx=%0d max=%h required 0 00000000", bus.idx, bus.max_val);
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
    endtask

    // Pulse start with vec at the next edge; optionally scramble `in` right after acceptance.
    // Checks done/busy for each cycle and the result in the done cycle.
    task automatic run_scan(input string name, input logic [N*S-1:0] vec,
                            input logic [IW-1:0] exp_idx, input logic [S-1:0] exp_val,
                            input bit scramble);
        bus.in    = vec;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (scramble) bus.in = {4{32'h7f800000}};
        for (int c = 0; c < 4; c++) begin
            n_assert++;
            if (bus.done !== (c == 3) || bus.busy !== (c < 3)) begin
                n_fail++;
                $display("FAIL %s_timing c=%0d: done=%b busy=%b required %b %b",
                         name, c, bus.done, bus.busy, (c == 3), (c < 3));
            end
            if (c == 3) begin
                n_assert++;
                if (bus.idx !== exp_idx || bus.max_val !== exp_val) begin
                    n_fail++;
                    $display("FAIL %s_result: idx=%0d max=%h required %0d %h",
                             name, bus.idx, bus.max_val, exp_idx, exp_val);
                end
            end
            @(negedge clk);
        end
        n_assert++;
        if (bus.done !== 1'b0 || bus.idx !== exp_idx || bus.max_val !== exp_val) begin
            n_fail++;
            $display("FAIL %s_hold: done=%b idx=%0d max=%h required 0 %0d %h",
                     name, bus.done, bus.idx, bus.max_val, exp_idx, exp_val);
        end
    endtask

    task automatic test_basic();
        run_scan("mixed", {32'h3f800000, 32'h40000000, 32'hbf800000, 32'h3f000000}, 2'd1, 32'h40000000, 1'b0);
        run_scan("allneg", {32'hbf800000, 32'hc0000000, 32'hbe800000, 32'hc0400000}, 2'd2, 32'hbe800000, 1'b0);
    endtask

    task automatic test_boundaries();
        run_scan("ties", {4{32'h40400000}}, 2'd0, 32'h40400000, 1'b0);
        run_scan("last", {32'h0, 32'h0, 32'h0, 32'h41200000}, 2'd3, 32'h41200000, 1'b0);
        run_scan("zeros", {32'h80000000, 32'h00000000, 32'h80000000, 32'hbf800000}, 2'd1, 32'h00000000, 1'b1);
    endtask

    task automatic test_abort();
        int dones;
        bus.in    = {32'h3f800000, 32'h40000000, 32'hbf800000, 32'h3f000000};
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_assert++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.idx !== 2'd0 || bus.max_val !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b done=%b idx=%0d max=%h required 0 0 0 00000000",
                     bus.busy, bus.done, bus.idx, bus.max_val);
        end
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        n_assert++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL abort_nodone: done pulses=%0d required 0", dones);
        end
        // start held high through the whole scan: only one result expected
        bus.start = 1'b1;
        dones = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        n_assert++;
        if (bus.done !== 1'b1 || bus.idx !== 2'd1 || bus.max_val !== 32'h40000000) begin
            n_fail++;
            $display("FAIL held_result: done=%b idx=%0d max=%h required 1 1 40000000",
                     bus.done, bus.idx, bus.max_val);
        end
        bus.start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        n_assert++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL held_single_done: done pulses=%0d required 1", dones);
        end
    endtask

    task automatic test_back_to_back();
        bus.in    = {32'h3f800000, 32'h40000000, 32'hbf800000, 32'h3f000000};
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        n_assert++;
        if (bus.done !== 1'b1 || bus.idx !== 2'd1 || bus.max_val !== 32'h40000000) begin
            n_fail++;
            $display("FAIL b2b_first: done=%b idx=%0d max=%h required 1 1 40000000",
                     bus.done, bus.idx, bus.max_val);
        end
        bus.in    = {32'hc0000000, 32'h3f800000, 32'h41000000, 32'h00000000};
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_assert++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.idx !== 2'd0 || bus.max_val !== 32'hc0000000) begin
            n_fail++;
            $display("FAIL b2b_reentry: done=%b busy=%b idx=%0d max=%h required 0 1 0 c0000000",
                     bus.done, bus.busy, bus.idx, bus.max_val);
        end
        repeat (3) @(negedge clk);
        n_assert++;
        if (bus.done !== 1'b1 || bus.idx !== 2'd2 || bus.max_val !== 32'h41000000) begin
            n_fail++;
            $display("FAIL b2b_second: done=%b idx=%0d max=%h required 1 2 41000000",
                     bus.done, bus.idx, bus.max_val);
        end
        @(negedge clk);
        n_assert++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done_drop: done=%b required 0", bus.done);
        end
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.in    = {(N*S){1'b0}};
        @(negedge clk);
        test_reset();
        test_basic();
        test_boundaries();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
